// File: rtl/sc_arb_pkg.sv
// Purpose: shared types and constants for the two-master data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sc_arb_pkg;

   // Width of the master-1 starvation counter (holds 0..15).
   localparam int STARVE_W       = 4;

   // Default number of consecutive denied master-1 cycles before a forced grant.
   localparam int STARVE_MAX_DEF = 4;

   // Read-response state: which master, if any, owns the data returning this cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2
   } rsp_state_e;

endpackage

// File: rtl/sc_arb_starve_ctr.sv
// Purpose: saturating count of consecutive cycles a requester was left waiting.
// Latency: count_o reflects the previous cycle's req/gnt (registered).
// Backpressure: none; clears whenever the requester is granted or withdraws.
//
// Ports:
//   clock, resetn : clock and asynchronous active-low reset
//   req_i, gnt_i  : requester's request and grant for this cycle
//   count_o       : current number of consecutive denied cycles, capped at MAX
module sc_arb_starve_ctr
   import sc_arb_pkg::*;
#(
   parameter int MAX = STARVE_MAX_DEF
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                req_i,
   input  logic                gnt_i,
   output logic [STARVE_W-1:0] count_o
);

   localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

   logic [STARVE_W-1:0] count_q;
   logic [STARVE_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (gnt_i || !req_i) begin
         // A grant or a dropped request both end the waiting streak.
         count_d = '0;
      end else if (count_q != MAX_C) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Purpose: shares one data-memory port between the CPU (m0, priority) and a secondary master (m1).
// Latency: grant and memory drive same cycle; read data/valid returned one cycle after the grant.
// Backpressure: a denied master sees gnt=0 and must hold req; nothing is buffered here.
//
// Ports:
//   clock, resetn                         : clock and asynchronous active-low reset
//   mN_req/we/addr/wdata                  : master N access request (one cycle per access)
//   mN_gnt                                : access accepted this cycle
//   mN_rvalid/rdata                       : read response, one cycle after a granted read
//   mem_addr/wdata/we, mem_rdata          : single data-memory port (1-cycle read latency)
//   starve_cnt                            : consecutive denied master-1 cycles (debug)
module sc_dmem_arbiter
   import sc_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_we,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [STARVE_W-1:0] starve_cnt
);

   localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

   logic       force1;
   logic       win0;
   logic       win1;
   rsp_state_e state_q;
   logic       m0_rvalid_q;
   logic       m1_rvalid_q;

   // ---------------------------------------------------------------
   // Arbitration: m0 has priority unless m1 has waited STARVE_MAX cycles.
   // ---------------------------------------------------------------
   assign force1 = (starve_cnt == STARVE_MAX_C) && m1_req;
   assign win1   = force1 || (m1_req && !m0_req);
   assign win0   = m0_req && !win1;

   assign m0_gnt = win0;
   assign m1_gnt = win1;

   // Only the winner's inputs reach memory; a non-requesting master's
   // we/addr/wdata may be X and are never looked at.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (win1) begin
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_we    = m1_we;
      end else if (win0) begin
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_we    = m0_we;
      end
   end

   sc_arb_starve_ctr #(
      .MAX     (STARVE_MAX)
   ) u_starve (
      .clock   (clock),
      .resetn  (resetn),
      .req_i   (m1_req),
      .gnt_i   (win1),
      .count_o (starve_cnt)
   );

   // ---------------------------------------------------------------
   // Response tracking: remembers who issued the read that memory is
   // answering this cycle. A new grant may overlap an outstanding
   // response, giving one access per cycle.
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
      end else begin
         if (win0 && !m0_we) begin
            state_q     <= RD0;
            m0_rvalid_q <= 1'b1;
            m1_rvalid_q <= 1'b0;
         end else if (win1 && !m1_we) begin
            state_q     <= RD1;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b1;
         end else begin
            // Writes and idle cycles produce no response.
            state_q     <= IDLE;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
         end
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;

   // Memory data is only forwarded to the owner; zero otherwise.
   assign m0_rdata  = (state_q == RD0) ? mem_rdata : '0;
   assign m1_rdata  = (state_q == RD1) ? mem_rdata : '0;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
module tb_sc_dmem_arbiter;

   localparam int SMAX = 4;

   logic        clock  = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata = '0;
   logic [3:0]  starve_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   sc_dmem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (SMAX)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .m0_req     (m0_req),
      .m0_we      (m0_we),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_gnt     (m0_gnt),
      .m0_rvalid  (m0_rvalid),
      .m0_rdata   (m0_rdata),
      .m1_req     (m1_req),
      .m1_we      (m1_we),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_gnt     (m1_gnt),
      .m1_rvalid  (m1_rvalid),
      .m1_rdata   (m1_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .starve_cnt (starve_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [7:0] a);
      case (a)
         8'h10:   return 32'hDEADBEEF;
         8'h04:   return 32'hA5A50004;
         8'h08:   return 32'h5A5A0008;
         default: return {16'hC0DE, 8'h00, a};
      endcase
   endfunction

   // Data memory device: one-cycle read latency, word selected by addr[7:0].
   logic [31:0]  dev [256];
   logic [255:0] written = '0;
   always @(posedge clock) begin
      if (mem_we) begin
         dev[mem_addr[7:0]]     <= mem_wdata;
         written[mem_addr[7:0]] <= 1'b1;
      end
      mem_rdata <= written[mem_addr[7:0]] ? dev[mem_addr[7:0]] : init_word(mem_addr[7:0]);
   end

   // ---------------- behavioural reference model ----------------
   int          mcnt  = 0;   // consecutive denied m1 cycles
   int          mpend = 0;   // 0 none, 1 m0 read, 2 m1 read returning this cycle
   logic [31:0] mpdata = '0;
   logic [31:0] shadow [256];
   bit          rst_seen = 1'b1;

   always @(negedge resetn) rst_seen = 1'b1;

   function automatic int winner();
      if (m1_req && (mcnt == SMAX || !m0_req)) return 2;
      if (m0_req) return 1;
      return 0;
   endfunction

   initial begin : compare
      int          w;
      logic [31:0] ea, ed;
      logic        ewe;
      for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
      forever begin
         @(negedge clock);
         #2;
         if (resetn) begin
            w   = winner();
            ea  = (w == 1) ? m0_addr  : (w == 2) ? m1_addr  : 32'h0;
            ed  = (w == 1) ? m0_wdata : (w == 2) ? m1_wdata : 32'h0;
            ewe = (w == 1) ? m0_we    : (w == 2) ? m1_we    : 1'b0;
            chk("m0_gnt",     32'(m0_gnt),     32'(w == 1));
            chk("m1_gnt",     32'(m1_gnt),     32'(w == 2));
            chk("mem_addr",   mem_addr,        ea);
            chk("mem_wdata",  mem_wdata,       ed);
            chk("mem_we",     32'(mem_we),     32'(ewe));
            chk("starve_cnt", 32'(starve_cnt), 32'(mcnt));
            chk("m0_rvalid",  32'(m0_rvalid),  32'(mpend == 1));
            chk("m1_rvalid",  32'(m1_rvalid),  32'(mpend == 2));
            chk("m0_rdata",   m0_rdata,        (mpend == 1) ? mpdata : 32'h0);
            chk("m1_rdata",   m1_rdata,        (mpend == 2) ? mpdata : 32'h0);
         end
         @(posedge clock);
         if (rst_seen || !resetn) begin
            mcnt     = 0;
            mpend    = 0;
            mpdata   = '0;
            rst_seen = 1'b0;
         end
         if (resetn) begin
            w = winner();
            if (w == 1 && !m0_we) begin
               mpend  = 1;
               mpdata = shadow[m0_addr[7:0]];
            end else if (w == 2 && !m1_we) begin
               mpend  = 2;
               mpdata = shadow[m1_addr[7:0]];
            end else begin
               mpend  = 0;
            end
            if (w == 1 && m0_we) shadow[m0_addr[7:0]] = m0_wdata;
            if (w == 2 && m1_we) shadow[m1_addr[7:0]] = m1_wdata;
            if (w == 2 || !m1_req) mcnt = 0;
            else if (mcnt < SMAX) mcnt++;
         end
      end
   end

   // Drives one cycle's inputs at the falling edge; idle masters get garbage
   // on their other inputs. Returns 3 time units later, after the model check.
   task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
      @(negedge clock);
      m0_req   = r0;
      m0_we    = r0 ? w0 : 1'($urandom);
      m0_addr  = r0 ? a0 : $urandom;
      m0_wdata = r0 ? d0 : $urandom;
      m1_req   = r1;
      m1_we    = r1 ? w1 : 1'($urandom);
      m1_addr  = r1 ? a1 : $urandom;
      m1_wdata = r1 ? d1 : $urandom;
      #3;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : stim
      // Reset
      idle();
      idle();
      chk("rst m0_rvalid", 32'(m0_rvalid), 32'h0);
      chk("rst m1_rvalid", 32'(m1_rvalid), 32'h0);
      chk("rst starve",    32'(starve_cnt), 32'h0);
      chk("rst m0_gnt",    32'(m0_gnt),     32'h0);
      chk("rst mem_we",    32'(mem_we),     32'h0);
      resetn = 1'b1;
      idle();

      // Single m0 read of 0x10
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
      chk("t1 m0_gnt",   32'(m0_gnt), 32'h1);
      chk("t1 mem_addr", mem_addr,    32'h10);
      idle();
      chk("t1 m0_rvalid", 32'(m0_rvalid), 32'h1);
      chk("t1 m0_rdata",  m0_rdata,       32'hDEADBEEF);
      chk("t1 m1_rvalid", 32'(m1_rvalid), 32'h0);

      // Both masters requesting continuously
      idle();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
         chk("t2 starve", 32'(starve_cnt), 32'(i % 5));
         chk("t2 m1_gnt", 32'(m1_gnt),     32'(i % 5 == 4));
         chk("t2 m0_gnt", 32'(m0_gnt),     32'(i % 5 != 4));
      end

      // m1 write then m0 read-back
      idle();
      drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
      chk("t3 mem_we wr", 32'(mem_we), 32'h1);
      chk("t3 m1_gnt",    32'(m1_gnt), 32'h1);
      drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
      chk("t3 mem_we rd",  32'(mem_we),    32'h0);
      chk("t3 m1_rvalid",  32'(m1_rvalid), 32'h0);
      idle();
      chk("t3 m0_rvalid", 32'(m0_rvalid), 32'h1);
      chk("t3 m0_rdata",  m0_rdata,       32'h55);

      // Back-to-back reads
      drive(1, 0, 32'h4, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
      chk("t4 m0_rvalid", 32'(m0_rvalid), 32'h1);
      chk("t4 m0_rdata",  m0_rdata,       32'hA5A50004);
      chk("t4 m1_rvalid", 32'(m1_rvalid), 32'h0);
      idle();
      chk("t4 m1_rvalid2", 32'(m1_rvalid), 32'h1);
      chk("t4 m1_rdata",   m1_rdata,       32'h5A5A0008);
      chk("t4 m0_rvalid2", 32'(m0_rvalid), 32'h0);

      // Reset in the middle of a read
      idle();
      drive(1, 0, 32'h10, 0, 1, 0, 32'h44, 0);
      drive(1, 0, 32'h10, 0, 1, 0, 32'h44, 0);
      drive(1, 0, 32'h10, 0, 1, 0, 32'h44, 0);
      chk("t5 starve pre", 32'(starve_cnt), 32'h2);
      chk("t5 m0_gnt",     32'(m0_gnt),     32'h1);
      resetn = 1'b0;
      m0_req = 1'b0;
      m1_req = 1'b0;
      #1;
      resetn = 1'b1;
      idle();
      chk("t5 m0_rvalid", 32'(m0_rvalid), 32'h0);
      chk("t5 m1_rvalid", 32'(m1_rvalid), 32'h0);
      chk("t5 starve",    32'(starve_cnt), 32'h0);

      // m1 request interrupted while m0 busy
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
         chk("t6 starve a", 32'(starve_cnt), 32'(i));
         chk("t6 m1_gnt a", 32'(m1_gnt),     32'h0);
      end
      drive(1, 0, 32'h30, 0, 0, 0, 0, 0);
      chk("t6 starve low", 32'(starve_cnt), 32'h3);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
         chk("t6 starve b", 32'(starve_cnt), 32'(i));
         chk("t6 m1_gnt b", 32'(m1_gnt),     32'(i == 4));
      end

      // Randomised traffic with occasional asynchronous reset pulses
      for (int n = 0; n < 800; n++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), {24'h0, 8'($urandom) & 8'hFC}, $urandom,
               $urandom_range(0, 2) != 0, 1'($urandom), {24'h0, 8'($urandom) & 8'hFC}, $urandom);
         if ($urandom_range(0, 99) == 0) begin
            resetn = 1'b0;
            #1;
            resetn = 1'b1;
         end
      end

      idle();
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
